cache_unit: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache placed between one CPU memory port (instruction port or data port) and a line-wide memory. The CPU sees a single-word interface with a `ready` stall signal. Memory is reached through a request/acknowledge handshake that moves whole lines. Two counters export hit and miss statistics for performance measurement.

---
 rtl/cache_unit.sv | 184 ++++++++++++++++++
 tb/tb_cache_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_unit.sv
// Direct-mapped, write-back, write-allocate cache between a single-word CPU
// port and a line-wide memory. A hit completes in the same cycle. A miss writes
// back a dirty victim if there is one, fills the line, and then completes as a hit.
module cache_unit #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            readM,
  input  logic                            writeM,
  input  logic [WORD_SIZE-1:0]            address,
  input  logic [WORD_SIZE-1:0]            data_in,
  output logic [WORD_SIZE-1:0]            data_out,
  output logic                            ready,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_ack,
  output logic [WORD_SIZE-1:0]            hit_count,
  output logic [WORD_SIZE-1:0]            miss_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic                 missed_q, missed_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] fill_addr_q, fill_addr_d;
  logic [WORD_SIZE-1:0] hit_count_q, hit_count_d;
  logic [WORD_SIZE-1:0] miss_count_q, miss_count_d;

  // Address fields of the CPU request and of the line being filled.
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign req_off  = address[OFF_W-1:0];
  assign req_idx  = address[OFF_W +: IDX_W];
  assign req_tag  = address[WORD_SIZE-1 -: TAG_W];
  assign fill_idx = fill_addr_q[OFF_W +: IDX_W];
  assign fill_tag = fill_addr_q[WORD_SIZE-1 -: TAG_W];

  logic req_valid, line_hit, hit_rdy, miss_start, cpu_wr, fill_done, wb_done;
  logic [OFF_W-1:0] zero_off;

  assign zero_off   = '0;
  assign req_valid  = readM | writeM;
  assign line_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_rdy    = (state_q == IDLE) && req_valid && line_hit && !Reset;
  assign miss_start = (state_q == IDLE) && req_valid && !line_hit && !Reset;
  assign cpu_wr     = hit_rdy && writeM;
  assign fill_done  = (state_q == FILL) && mem_ack;
  assign wb_done    = (state_q == WRITEBACK) && mem_ack;

  assign ready      = hit_rdy;
  assign data_out   = hit_rdy ? data_q[req_idx][int'(req_off)*WORD_SIZE +: WORD_SIZE] : '0;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Next-state logic for the miss sequencer, memory request outputs and counters.
  always_comb begin
    state_d      = state_q;
    missed_d     = missed_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_addr_d  = fill_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          miss_count_d = miss_count_q + WORD_SIZE'(1);
          missed_d     = 1'b1;
          mem_req_d    = 1'b1;
          fill_addr_d  = {req_tag, req_idx, zero_off};
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d     = WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[req_idx], req_idx, zero_off};
            mem_wdata_d = data_q[req_idx];
          end else begin
            state_d    = FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx, zero_off};
          end
        end else if (hit_rdy) begin
          // The completing cycle of a missed access was already counted as a miss.
          missed_d = 1'b0;
          if (!missed_q) begin
            hit_count_d = hit_count_q + WORD_SIZE'(1);
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          state_d    = FILL;
          mem_we_d   = 1'b0;
          mem_addr_d = fill_addr_q;
        end
      end
      FILL: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, registered memory outputs, counters and per-line valid/dirty/tag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      missed_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      missed_q     <= missed_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_addr_q  <= fill_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      // The victim shares its index with the pending fill.
      if (wb_done) begin
        dirty_q[fill_idx] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
        tag_q[fill_idx]   <= fill_tag;
      end
      if (cpu_wr) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Line storage: whole-line fill from memory or single-word merge from the CPU.
  always_ff @(posedge Clk) begin
    if (fill_done) begin
      data_q[fill_idx] <= mem_rdata;
    end else if (cpu_wr) begin
      data_q[req_idx][int'(req_off)*WORD_SIZE +: WORD_SIZE] <= data_in;
    end
  end

endmodule

// File: tb/tb_cache_unit.sv
// Bench for cache_unit: a line-level memory responder, an access-level model
// of the cache, and one compare process that checks outputs every cycle.
module tb_cache_unit;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int NL = 4;

  logic          Clk, Reset, readM, writeM, mem_ack;
  logic [W-1:0]  address, data_in, data_out, mem_addr, hit_count, miss_count;
  logic          ready, mem_req, mem_we;
  logic [W*LW-1:0] mem_wdata, mem_rdata;

  cache_unit #(.WORD_SIZE(W), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .Clk(Clk), .Reset(Reset), .readM(readM), .writeM(writeM),
    .address(address), .data_in(data_in), .data_out(data_out), .ready(ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Backing memory: untouched words read as address ^ 0xA5A5.
  logic [15:0] mem_m [logic [15:0]];
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 16'hA5A5;
  endfunction

  // Model cache state.
  bit          m_valid [NL];
  bit          m_dirty [NL];
  int          m_tag   [NL];
  logic [15:0] m_data  [NL][LW];
  int          m_hit, m_miss;

  // Expectations for the access in flight.
  bit          e_miss_acc, e_wb, e_rd;
  logic [15:0] e_wb_addr, e_fill_addr, e_data;
  logic [63:0] e_wb_line;
  int          e_lat, e_hit_cnt, e_miss_cnt;

  int ack_lat = 3;
  int late_cnt = 0;
  int acc_id = 0;
  int pin_step = 0;
  bit chk_en = 1'b0;

  // Compare-process state.
  int n_chk = 0, n_fail = 0;
  int done_id = 0, seen_id = 0, cyc = 0, phase = 0, pin_done = 0;
  int last_lat;
  logic [15:0] last_data, last_fill_addr, last_wb_addr;
  logic [63:0] last_wb_line;

  // Memory responder: acks the ack_lat-th cycle of a continuous request.
  int req_cycles = 0;
  int late_seen = 0;
  always @(posedge Clk) begin
    #1;
    mem_ack = 1'b0;
    if (late_cnt != late_seen) begin
      late_seen = late_cnt;
      mem_ack = 1'b1;
    end else if (Reset || !mem_req) begin
      req_cycles = 0;
    end else begin
      req_cycles++;
      if (req_cycles == ack_lat) begin
        mem_ack = 1'b1;
        for (int w = 0; w < LW; w++) mem_rdata[w*16 +: 16] = mem_rd(mem_addr + 16'(w));
        req_cycles = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare process: model checks on every request/idle cycle, plus literal pins.
  always @(negedge Clk) begin
    if (chk_en) begin
      if (!(readM || writeM)) begin
        chk("idle_ready", ready, 0);
        chk("idle_data", data_out, 0);
        chk("idle_req", mem_req, 0);
      end else begin
        if (acc_id != seen_id) begin
          seen_id = acc_id; cyc = 0; phase = 0;
        end
        if (mem_req) begin
          if (!e_miss_acc) begin
            chk("req_on_hit", mem_req, 0);
          end else if (e_wb && phase == 0) begin
            chk("wb_we", mem_we, 1);
            chk("wb_addr", mem_addr, e_wb_addr);
            chk("wb_line", mem_wdata, e_wb_line);
            last_wb_addr = mem_addr;
            last_wb_line = mem_wdata;
          end else begin
            chk("fill_we", mem_we, 0);
            chk("fill_addr", mem_addr, e_fill_addr);
            last_fill_addr = mem_addr;
          end
          if (mem_ack) phase++;
        end
        if (ready) begin
          chk("latency", cyc, e_lat);
          if (e_rd) chk("rdata", data_out, e_data);
          chk("hit_cnt", hit_count, 16'(e_hit_cnt));
          chk("miss_cnt", miss_count, 16'(e_miss_cnt));
          last_data = data_out;
          last_lat = cyc;
          $display("access %0d addr %h rd %0b wr %0b lat %0d data %h hits %0d misses %0d",
                   acc_id, address, readM, writeM, cyc, data_out, hit_count, miss_count);
          done_id = acc_id;
        end else if (cyc > 300) begin
          chk("timeout", ready, 1);
          done_id = acc_id;
        end
        cyc++;
      end
    end
    if (pin_step != pin_done) begin
      pin_done = pin_step;
      case (pin_step)
        1: begin
          chk("rst_ready", ready, 0);   chk("rst_data", data_out, 0);
          chk("rst_req", mem_req, 0);   chk("rst_we", mem_we, 0);
          chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
          chk("rst_hits", hit_count, 0); chk("rst_miss", miss_count, 0);
        end
        2: begin
          chk("cold_data", last_data, 16'hA5B5); chk("cold_lat", last_lat, 4);
          chk("cold_fill", last_fill_addr, 16'h0010);
          chk("cold_miss", miss_count, 1); chk("cold_hits", hit_count, 0);
        end
        3: begin chk("hits2", hit_count, 2); chk("hit_lat", last_lat, 0); end
        4: begin
          chk("dirty_wb_addr", last_wb_addr, 16'h0010);
          chk("dirty_wb_w2", last_wb_line[47:32], 16'hBEEF);
          chk("dirty_fill", last_fill_addr, 16'h0000);
          chk("dirty_miss", miss_count, 2); chk("dirty_lat", last_lat, 7);
          chk("dirty_data", last_data, 16'hA5A5);
        end
        5: begin chk("wmiss_read", last_data, 16'h5A5A); chk("wmiss_lat", last_lat, 0); end
        6: begin
          chk("evict_addr", last_wb_addr, 16'h0024);
          chk("evict_w0", last_wb_line[15:0], 16'h5A5A);
          chk("refill_data", last_data, 16'h5A5A);
        end
        7: chk("dual_data", last_data, 16'h1234);
        8: begin
          chk("midrst_ready", ready, 0); chk("midrst_data", data_out, 0);
          chk("midrst_req_before", mem_req, 1);
        end
        9: begin
          chk("postrst_req", mem_req, 0); chk("postrst_we", mem_we, 0);
          chk("postrst_hits", hit_count, 0); chk("postrst_miss", miss_count, 0);
        end
        10: begin chk("lateack_req", mem_req, 0); chk("lateack_ready", ready, 0); end
        11: begin
          chk("reread_lat", last_lat, 4); chk("reread_miss", miss_count, 1);
          chk("reread_data", last_data, 16'hA5B5);
        end
        default: ;
      endcase
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit = 0;
    m_miss = 0;
  endtask

  // One CPU access: predict from the model, drive, wait for completion.
  task automatic access(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d);
    int idx, off, tg;
    bit hit;
    idx = (int'(a) / LW) % NL;
    off = int'(a) % LW;
    tg  = int'(a) / (LW * NL);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    e_miss_acc  = !hit;
    e_wb        = !hit && m_valid[idx] && m_dirty[idx];
    e_wb_addr   = 16'(m_tag[idx] * LW * NL + idx * LW);
    for (int w = 0; w < LW; w++) e_wb_line[w*16 +: 16] = m_data[idx][w];
    e_fill_addr = 16'(int'(a) - off);
    if (!hit) begin
      if (e_wb) for (int w = 0; w < LW; w++) mem_m[e_wb_addr + 16'(w)] = m_data[idx][w];
      m_miss++;
      for (int w = 0; w < LW; w++) m_data[idx][w] = mem_rd(e_fill_addr + 16'(w));
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    e_rd       = rd && !wr;
    e_data     = m_data[idx][off];
    e_hit_cnt  = m_hit;
    e_miss_cnt = m_miss;
    e_lat      = hit ? 0 : (e_wb ? 2 * ack_lat + 1 : ack_lat + 1);
    if (wr) begin
      m_data[idx][off] = d;
      m_dirty[idx] = 1'b1;
    end
    if (hit) m_hit++;
    @(posedge Clk); #1;
    readM = rd; writeM = wr; address = a; data_in = d;
    acc_id++;
    while (done_id != acc_id) @(posedge Clk);
    #1;
    readM = 1'b0; writeM = 1'b0;
  endtask

  task automatic pin(input int s);
    @(posedge Clk); #1;
    pin_step = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; readM = 1'b0; writeM = 1'b0; address = '0; data_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    @(posedge Clk); #1;
    pin_step = 1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk_en = 1'b1;

    access(0, 1, 16'h0010, 16'h0000); pin(2);
    access(0, 1, 16'h0011, 16'h0000);
    access(0, 1, 16'h0013, 16'h0000); pin(3);
    access(1, 0, 16'h0012, 16'hBEEF);
    access(0, 1, 16'h0000, 16'h0000); pin(4);
    access(1, 0, 16'h0024, 16'h5A5A);
    access(0, 1, 16'h0024, 16'h0000); pin(5);
    access(0, 1, 16'h0004, 16'h0000);
    access(0, 1, 16'h0024, 16'h0000); pin(6);
    access(0, 1, 16'h0010, 16'h0000);
    access(1, 1, 16'h0011, 16'h1234);
    access(0, 1, 16'h0011, 16'h0000); pin(7);

    // Reset in the second cycle of an outstanding fill, then a stray ack.
    chk_en = 1'b0;
    ack_lat = 100;
    @(posedge Clk); #1; readM = 1'b1; address = 16'h0038;
    @(posedge Clk); #1;
    @(posedge Clk); #1; Reset = 1'b1; pin_step = 8;
    @(posedge Clk); #1; Reset = 1'b0; readM = 1'b0; pin_step = 9;
    late_cnt++;
    @(posedge Clk); #1;
    @(posedge Clk); #1; pin_step = 10;
    model_reset();
    ack_lat = 3;
    chk_en = 1'b1;
    access(0, 1, 16'h0010, 16'h0000); pin(11);

    repeat (3) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
